mp_regfile: RTL and testbench
=============================

MP_REGFILE -- requirements
Module: mp_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL have parameter NREG, default 32, meaning register count (power of two, at least 2); ADDR_W = log2(NREG).
REQ-003 SHALL have parameter NRD, default 4, meaning read-port count.
REQ-004 SHALL have parameter NWR, default 2, meaning write-port and allocate-port count.
REQ-005 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on posedge.
REQ-006 SHALL have port reset, input, 1 bit, meaning synchronous active-high reset.
REQ-007 SHALL have port ra, input, NRD x ADDR_W, meaning read addresses.
REQ-008 SHALL have port rd, output, NRD x DATA_W, meaning read data.
REQ-009 SHALL have port rbusy, output, NRD bits, meaning the addressed register has a pending producer.
REQ-010 SHALL have port we, input, NWR bits, meaning write enables.
REQ-011 SHALL have port wa, input, NWR x ADDR_W, meaning write addresses.
REQ-012 SHALL have port wd, input, NWR x DATA_W, meaning write data.
REQ-013 SHALL have port alloc_en, input, NWR bits, meaning issue-time destination reservation enables.
REQ-014 SHALL have port alloc_a, input, NWR x ADDR_W, meaning reserved destination addresses.

Function
REQ-015 SHALL update register wa[i] with wd[i] at posedge when we[i]=1 and wa[i]!=0.
REQ-016 SHALL resolve same-cycle writes to one address in favour of the highest port index.
REQ-017 SHALL keep register 0 at zero: rd[j]=0 and rbusy[j]=0 whenever ra[j]=0, and writes or allocates to address 0 SHALL be ignored.
REQ-018 SHALL make reads combinational, with zero-cycle latency from ra to rd and rbusy.
REQ-019 SHALL keep one busy bit per register in a scoreboard.
REQ-020 SHALL set busy[alloc_a[i]] at posedge when alloc_en[i]=1.
REQ-021 SHALL clear busy[wa[i]] at posedge when we[i]=1.
REQ-022 SHALL give allocate priority over clear when both target the same register in the same cycle, so the busy bit ends set because the new producer supersedes the old one.
REQ-023 SHALL accept a write to a non-busy register and update it normally, with the busy bit remaining 0.
REQ-024 SHALL produce no cross-port interaction other than the rules in REQ-016 and REQ-022.

Reset
REQ-025 SHALL clear all registers and all busy bits at the first posedge with reset=1.
REQ-026 SHALL let reset dominate any we or alloc_en in the same cycle, discarding those updates.
REQ-027 SHALL drive rd=0 and rbusy=0 for every read address in the cycle after reset, for any ra.

Configuration
REQ-028 SHALL, with REGFILE_BYPASS_EN defined, return wd of the highest-index port with we[i]=1 and wa[i]=ra[j]!=0 on rd[j] in the same cycle.
REQ-029 SHALL, with REGFILE_BYPASS_EN defined and such a write matching, drive rbusy[j]=0 unless an alloc_en[k] in the same cycle targets ra[j].
REQ-030 SHALL, without REGFILE_BYPASS_EN, return only registered state on rd and rbusy, so write data becomes visible one cycle after the write.

Structure
REQ-031 SHALL place the default DATA_W and NREG constants and the reg_addr_t and reg_data_t typedefs in shared package rf_pkg.
REQ-032 SHALL implement the busy-bit array with allocate/clear priority as sub-module rf_scoreboard, instantiated once.
REQ-033 SHALL be implementable in 120-400 lines of RTL.

Verification
REQ-034 SHALL cover: reset, then read all 32 addresses -> all rd=0 and all rbusy=0.
REQ-035 SHALL cover: we[0]=1, wa[0]=5, wd[0]=0xDEADBEEF, and in the same cycle we[1]=1, wa[1]=5, wd[1]=0x12345678 -> reg5=0x12345678 on the next cycle.
REQ-036 SHALL cover: write 0xFFFFFFFF to address 0 -> ra=0 returns 0 and rbusy=0.
REQ-037 SHALL cover: alloc reg7 in cycle N -> rbusy=1 from cycle N+1; write reg7=0xA5 in cycle N+3 -> rbusy=0 and rd=0xA5 from cycle N+4.
REQ-038 SHALL cover: alloc_a[1]=9 and we[0]=1 with wa[0]=9 in the same cycle -> reg9 updated and busy9=1 on the next cycle.
REQ-039 SHALL cover: write reg3=0x55 while ra[2]=3 in the same cycle -> rd[2]=0x55 that cycle with REGFILE_BYPASS_EN, and the old value without it.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and typedefs for the multi-port register file.
// Imported by mp_regfile, rf_scoreboard and the bench.
package rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_NREG   = 32;
    localparam int RF_ADDR_W = $clog2(RF_NREG);

    typedef logic [RF_DATA_W-1:0] reg_data_t;
    typedef logic [RF_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// One busy bit per register: set on allocate, cleared on write-back.
// Allocate wins over clear so a newer producer is never lost.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int NREG   = RF_NREG,
    parameter  int NWR    = 2,
    localparam int ADDR_W = $clog2(NREG)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NWR-1:0]               i_clr_en,
    input  logic [NWR-1:0][ADDR_W-1:0]   i_clr_a,
    input  logic [NWR-1:0]               i_alloc_en,
    input  logic [NWR-1:0][ADDR_W-1:0]   i_alloc_a,
    output logic [NREG-1:0]              o_busy
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;

    // All clears first, then all sets: gives allocate priority on collisions.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 0; i < NWR; i++) begin
            if (i_clr_en[i]) w_busy_nxt[i_clr_a[i]] = 1'b0;
        end
        for (int i = 0; i < NWR; i++) begin
            if (i_alloc_en[i]) w_busy_nxt[i_alloc_a[i]] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) r_busy <= '0;
        else       r_busy <= w_busy_nxt;
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/mp_regfile.sv
// Multi-port register file with combinational reads and a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto read ports.
module mp_regfile
    import rf_pkg::*;
#(
    parameter  int DATA_W = RF_DATA_W,
    parameter  int NREG   = RF_NREG,
    parameter  int NRD    = 4,
    parameter  int NWR    = 2,
    localparam int ADDR_W = $clog2(NREG)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NRD-1:0][ADDR_W-1:0]   ra,
    output logic [NRD-1:0][DATA_W-1:0]   rd,
    output logic [NRD-1:0]               rbusy,
    input  logic [NWR-1:0]               we,
    input  logic [NWR-1:0][ADDR_W-1:0]   wa,
    input  logic [NWR-1:0][DATA_W-1:0]   wd,
    input  logic [NWR-1:0]               alloc_en,
    input  logic [NWR-1:0][ADDR_W-1:0]   alloc_a
);

    logic [DATA_W-1:0] r_regs [NREG];
    logic [NREG-1:0]   w_busy;
    logic [NRD-1:0]    w_hit;

    rf_scoreboard #(
        .NREG (NREG),
        .NWR  (NWR)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .i_clr_en   (we),
        .i_clr_a    (wa),
        .i_alloc_en (alloc_en),
        .i_alloc_a  (alloc_a),
        .o_busy     (w_busy)
    );

    // Ascending port loop: the highest index lands last and wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NREG; k++) r_regs[k] <= '0;
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (we[i] && (wa[i] != '0)) r_regs[wa[i]] <= wd[i];
            end
        end
    end

    always_comb begin
        w_hit = '0;
        for (int j = 0; j < NRD; j++) begin
            rd[j]    = r_regs[ra[j]];
            rbusy[j] = w_busy[ra[j]];
`ifdef REGFILE_BYPASS_EN
            for (int i = 0; i < NWR; i++) begin
                if (we[i] && (wa[i] == ra[j])) begin
                    rd[j]    = wd[i];
                    w_hit[j] = 1'b1;
                end
            end
            // A forwarded write retires the producer unless a new one issues now.
            if (w_hit[j]) begin
                rbusy[j] = 1'b0;
                for (int k = 0; k < NWR; k++) begin
                    if (alloc_en[k] && (alloc_a[k] == ra[j])) rbusy[j] = 1'b1;
                end
            end
`endif
            if (ra[j] == '0) begin
                rd[j]    = '0;
                rbusy[j] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mp_regfile.sv
// Self-checking bench for mp_regfile: directed corner cases then random traffic
// against an array-based reference model.
module tb_mp_regfile;
    import rf_pkg::*;

    localparam int NRD = 4;
    localparam int NWR = 2;

    logic                            clk;
    logic                            reset;
    logic [NRD-1:0][RF_ADDR_W-1:0]   ra;
    logic [NRD-1:0][RF_DATA_W-1:0]   rd;
    logic [NRD-1:0]                  rbusy;
    logic [NWR-1:0]                  we;
    logic [NWR-1:0][RF_ADDR_W-1:0]   wa;
    logic [NWR-1:0][RF_DATA_W-1:0]   wd;
    logic [NWR-1:0]                  alloc_en;
    logic [NWR-1:0][RF_ADDR_W-1:0]   alloc_a;

    reg_data_t mdl_regs [RF_NREG];
    bit        mdl_busy [RF_NREG];

    int n_vec = 0;
    int n_err = 0;

    mp_regfile #(
        .DATA_W (RF_DATA_W),
        .NREG   (RF_NREG),
        .NRD    (NRD),
        .NWR    (NWR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ra       (ra),
        .rd       (rd),
        .rbusy    (rbusy),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .alloc_en (alloc_en),
        .alloc_a  (alloc_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural state change for the inputs present at the coming edge.
    task automatic model_edge();
        if (reset) begin
            for (int a = 0; a < RF_NREG; a++) begin
                mdl_regs[a] = '0;
                mdl_busy[a] = 1'b0;
            end
        end else begin
            bit alloc_hit [RF_NREG];
            bit clr_hit   [RF_NREG];
            for (int a = 0; a < RF_NREG; a++) begin
                alloc_hit[a] = 1'b0;
                clr_hit[a]   = 1'b0;
            end
            for (int p = 0; p < NWR; p++) begin
                if (we[p]) begin
                    clr_hit[wa[p]] = 1'b1;
                    if (wa[p] != 0) mdl_regs[wa[p]] = wd[p];
                end
                if (alloc_en[p]) alloc_hit[alloc_a[p]] = 1'b1;
            end
            for (int a = 1; a < RF_NREG; a++) begin
                if (alloc_hit[a])    mdl_busy[a] = 1'b1;
                else if (clr_hit[a]) mdl_busy[a] = 1'b0;
            end
        end
    endtask

    task automatic exp_read(input reg_addr_t a, output reg_data_t d, output logic b);
        d = mdl_regs[a];
        b = mdl_busy[a];
`ifdef REGFILE_BYPASS_EN
        begin
            bit hit = 1'b0;
            for (int p = 0; p < NWR; p++) begin
                if (we[p] && wa[p] == a) begin
                    d   = wd[p];
                    hit = 1'b1;
                end
            end
            if (hit) begin
                b = 1'b0;
                for (int p = 0; p < NWR; p++)
                    if (alloc_en[p] && alloc_a[p] == a) b = 1'b1;
            end
        end
`endif
        if (a == 0) begin
            d = '0;
            b = 1'b0;
        end
    endtask

    task automatic check_reads(input string tag);
        reg_data_t ed;
        logic      eb;
        #1;
        for (int j = 0; j < NRD; j++) begin
            exp_read(ra[j], ed, eb);
            chk($sformatf("%s rd%0d a%0d", tag, j, ra[j]), rd[j], ed);
            chk($sformatf("%s rbusy%0d a%0d", tag, j, ra[j]), {31'd0, rbusy[j]}, {31'd0, eb});
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = '0; wa = '0; wd = '0; alloc_en = '0; alloc_a = '0;
    endtask

    initial begin
        reset = 1'b1;
        ra = '0;
        idle();
        for (int a = 0; a < RF_NREG; a++) begin
            mdl_regs[a] = 32'hBAD0_0000;
            mdl_busy[a] = 1'b1;
        end
        tick();
        tick();
        reset = 1'b0;

        // all 32 addresses read back zero and not busy after reset
        for (int g = 0; g < RF_NREG / NRD; g++) begin
            for (int j = 0; j < NRD; j++) ra[j] = RF_ADDR_W'(g * NRD + j);
            check_reads("post_reset");
            for (int j = 0; j < NRD; j++) chk("post_reset_const", rd[j], 32'h0);
        end

        // two ports writing the same register: port 1 wins
        we = 2'b11; wa[0] = 5; wd[0] = 32'hDEADBEEF; wa[1] = 5; wd[1] = 32'h12345678;
        tick();
        idle();
        ra[0] = 5;
        check_reads("same_addr");
        chk("same_addr_const", rd[0], 32'h12345678);

        // writes and allocates to register 0 are ignored
        we = 2'b01; wa[0] = 0; wd[0] = 32'hFFFFFFFF; alloc_en = 2'b10; alloc_a[1] = 0;
        tick();
        idle();
        ra[1] = 0;
        check_reads("reg0");
        chk("reg0_rd", rd[1], 32'h0);
        chk("reg0_busy", {31'd0, rbusy[1]}, 32'h0);

        // allocate reg7, write back three cycles later
        alloc_en = 2'b01; alloc_a[0] = 7;
        tick();
        idle();
        ra[2] = 7;
        check_reads("alloc7_n1");
        chk("alloc7_busy", {31'd0, rbusy[2]}, 32'h1);
        tick();
        check_reads("alloc7_n2");
        tick();
        we = 2'b10; wa[1] = 7; wd[1] = 32'hA5;
        check_reads("alloc7_n3");
        tick();
        idle();
        check_reads("alloc7_n4");
        chk("alloc7_rd", rd[2], 32'hA5);
        chk("alloc7_clr", {31'd0, rbusy[2]}, 32'h0);

        // allocate and write-back to reg9 in one cycle: busy stays set
        alloc_en = 2'b10; alloc_a[1] = 9; we = 2'b01; wa[0] = 9; wd[0] = 32'h0000_9999;
        tick();
        idle();
        ra[3] = 9;
        check_reads("alloc_vs_clr");
        chk("alloc_vs_clr_rd", rd[3], 32'h0000_9999);
        chk("alloc_vs_clr_busy", {31'd0, rbusy[3]}, 32'h1);

        // read of reg3 in the cycle it is written
        we = 2'b01; wa[0] = 3; wd[0] = 32'h11;
        tick();
        ra[2] = 3; wd[0] = 32'h55;
        check_reads("bypass");
`ifdef REGFILE_BYPASS_EN
        chk("bypass_rd", rd[2], 32'h55);
`else
        chk("bypass_rd", rd[2], 32'h11);
`endif
        tick();
        idle();
        check_reads("bypass_after");
        chk("bypass_after_rd", rd[2], 32'h55);

        // reset dominates simultaneous write/allocate
        reset = 1'b1; we = 2'b11; wa[0] = 4; wa[1] = 6; wd[0] = 32'h4444; wd[1] = 32'h6666;
        alloc_en = 2'b11; alloc_a[0] = 4; alloc_a[1] = 9;
        tick();
        reset = 1'b0;
        idle();
        ra[0] = 4; ra[1] = 6; ra[2] = 9; ra[3] = 5;
        check_reads("reset_dom");
        for (int j = 0; j < NRD; j++) begin
            chk("reset_dom_rd", rd[j], 32'h0);
            chk("reset_dom_busy", {31'd0, rbusy[j]}, 32'h0);
        end

        // random traffic concentrated on a few registers to force collisions
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 59) == 0);
            for (int p = 0; p < NWR; p++) begin
                we[p]       = $urandom_range(0, 1);
                wa[p]       = RF_ADDR_W'($urandom_range(0, 7));
                wd[p]       = $urandom;
                alloc_en[p] = ($urandom_range(0, 2) == 0);
                alloc_a[p]  = RF_ADDR_W'($urandom_range(0, 7));
            end
            for (int j = 0; j < NRD; j++)
                ra[j] = ($urandom_range(0, 3) == 0) ? RF_ADDR_W'($urandom_range(0, 31))
                                                    : RF_ADDR_W'($urandom_range(0, 7));
            check_reads("rand");
            tick();
        end
        reset = 1'b0;
        idle();
        check_reads("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
